// File: rtl/reg_port_arbiter_if.sv
// Requester-side and register-file-side bus of reg_port_arbiter.
// Defining REG_ARB_LOCK_EN adds the per-requester lock vector.
interface reg_port_arbiter_if #(
    parameter int n    = 8,
    parameter int AW   = 5,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we_in;
    logic [NREQ*AW-1:0] addr_in;
    logic [NREQ*n-1:0]  wdata_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [n-1:0]       rdata;
    logic               busy;
    logic               reg_w;
    logic [AW-1:0]      reg_addr;
    logic [n-1:0]       reg_wdata;
    logic [n-1:0]       reg_rdata;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif

    modport slave (
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        input  req, we_in, addr_in, wdata_in, reg_rdata,
        output gnt, rvalid, rdata, busy, reg_w, reg_addr, reg_wdata
    );

    modport master (
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        output req, we_in, addr_in, wdata_in, reg_rdata,
        input  gnt, rvalid, rdata, busy, reg_w, reg_addr, reg_wdata
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing the pMIPS register-file port among NREQ requesters.
// Define REG_ARB_LOCK_EN to let a granted requester hold top priority via lock[i].
module reg_port_arbiter #(
    parameter int n    = 8,
    parameter int AW   = 5,
    parameter int NREQ = 3
) (
    input logic               clk,
    input logic               nReset,
    reg_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   win;
    logic            hit;
    logic [NREQ-1:0] gnt_c;
    logic [NREQ-1:0] rd_p1;
    logic [NREQ-1:0] rvalid_q;
    logic            reg_w_q;
    logic [AW-1:0]   reg_addr_q;
    logic [n-1:0]    reg_wdata_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx   = '0;
        win   = '0;
        hit   = 1'b0;
        gnt_c = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(ptr) + off) % NREQ);
            if (!hit && bus.req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
        if (hit) gnt_c[win] = 1'b1;
    end

    always_comb begin
        ptr_nxt = ptr;
        if (hit) begin
`ifdef REG_ARB_LOCK_EN
            if (bus.lock[win]) ptr_nxt = win;
            else               ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`else
            ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            // NOTE: the read pipe is reset too, so reads in flight at reset never return.
            ptr         <= '0;
            reg_w_q     <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rd_p1       <= '0;
            rvalid_q    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so all flops sample pre-edge values.
            ptr      <= ptr_nxt;
            reg_w_q  <= hit & bus.we_in[win];
            rd_p1    <= (hit && !bus.we_in[win]) ? gnt_c : '0;
            rvalid_q <= rd_p1;
            if (hit) begin
                reg_addr_q  <= bus.addr_in[int'(win)*AW +: AW];
                reg_wdata_q <= bus.wdata_in[int'(win)*n +: n];
            end
        end
    end

    assign bus.gnt       = nReset ? gnt_c : '0;
    assign bus.reg_w     = reg_w_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.reg_rdata;
    assign bus.busy      = (|rd_p1) | (|rvalid_q);
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed and randomized bench for reg_port_arbiter with a register-file model
// and a queue-based reference of grants, issues and read returns.
module tb_reg_port_arbiter;
    localparam int N    = 8;
    localparam int AW   = 5;
    localparam int NREQ = 3;

    logic clk    = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    reg_port_arbiter_if #(.n(N), .AW(AW), .NREQ(NREQ)) bus ();
    reg_port_arbiter #(.n(N), .AW(AW), .NREQ(NREQ)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    // Synchronous register file: %0 always reads as zero.
    logic [N-1:0] rf [32] = '{default: '0};
    always @(posedge clk) begin
        if (bus.reg_w && bus.reg_addr != 0) rf[bus.reg_addr] <= bus.reg_wdata;
        bus.reg_rdata <= (bus.reg_addr == 0) ? '0 : rf[bus.reg_addr];
    end

    typedef struct {
        int           due;
        int           idx;
        logic [N-1:0] data;
    } ret_t;

    ret_t            rq[$];
    logic [N-1:0]    shadow [32];
    int              mptr, cyc, checks, errors, last_w;
    logic            exp_w;
    logic [AW-1:0]   exp_addr;
    logic [N-1:0]    exp_wdata;
    logic [NREQ-1:0] obs_gnt;
    logic [NREQ-1:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        mptr      = 0;
        exp_w     = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [N-1:0] d);
        bus.req[i]               = 1'b1;
        bus.we_in[i]             = we;
        bus.addr_in[i*AW +: AW]  = a;
        bus.wdata_in[i*N +: N]   = d;
    endtask

    // One clock: check the grant against the rotation rule, advance the model,
    // then check the registered outputs just after the edge.
    task automatic cycle();
        logic [NREQ-1:0] eg, erv;
        logic [AW-1:0]   a;
        logic [N-1:0]    d, erd;
        logic            eb;
        ret_t            r;
        #1;
        last_w = -1;
        eg     = '0;
        for (int off = 0; off < NREQ; off++)
            if (last_w < 0 && bus.req[(mptr + off) % NREQ]) last_w = (mptr + off) % NREQ;
        if (last_w >= 0) eg[last_w] = 1'b1;
        obs_gnt = bus.gnt;
        chk("gnt", bus.gnt, eg);
        if (last_w >= 0) begin
            a         = bus.addr_in[last_w*AW +: AW];
            d         = bus.wdata_in[last_w*N +: N];
            exp_w     = bus.we_in[last_w];
            exp_addr  = a;
            exp_wdata = d;
            if (bus.we_in[last_w]) begin
                if (a != 0) shadow[a] = d;
            end else begin
                r.due  = cyc + 2;
                r.idx  = last_w;
                r.data = shadow[a];
                rq.push_back(r);
            end
`ifdef REG_ARB_LOCK_EN
            mptr = bus.lock[last_w] ? last_w : (last_w + 1) % NREQ;
`else
            mptr = (last_w + 1) % NREQ;
`endif
        end else begin
            exp_w = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        erv = '0;
        erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].idx] = 1'b1;
            erd = rq[0].data;
            void'(rq.pop_front());
        end
        eb = (erv != 0) || (rq.size() > 0 && rq[0].due == cyc + 1);
        chk("reg_w", bus.reg_w, exp_w);
        chk("reg_addr", bus.reg_addr, exp_addr);
        chk("reg_wdata", bus.reg_wdata, exp_wdata);
        chk("rvalid", bus.rvalid, erv);
        chk("busy", bus.busy, eb);
        if (erv != 0) chk("rdata", bus.rdata, erd);
    endtask

    initial begin
        bus.req      = '0;
        bus.we_in    = '0;
        bus.addr_in  = '0;
        bus.wdata_in = '0;
`ifdef REG_ARB_LOCK_EN
        bus.lock     = '0;
`endif
        foreach (shadow[i]) shadow[i] = '0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_reset();

        // Reset values, grant forced low while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_w", bus.reg_w, 0);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_reg_wdata", bus.reg_wdata, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_busy", bus.busy, 0);
        bus.req = 3'b111;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        bus.req = '0;
        nReset  = 1'b1;

        // Write r3 = 13 from requester 0.
        set_req(0, 1'b1, 5'd3, 8'd13);
        cycle();
        chk("t1_gnt", obs_gnt, 3'b001);
        chk("t1_reg_w", bus.reg_w, 1);
        chk("t1_reg_addr", bus.reg_addr, 3);
        chk("t1_reg_wdata", bus.reg_wdata, 13);
        bus.req = '0;
        cycle();
        chk("t1_reg_w_off", bus.reg_w, 0);

        // Read r3 from requester 1.
        set_req(1, 1'b0, 5'd3, 8'd0);
        cycle();
        chk("t2_gnt", obs_gnt, 3'b010);
        chk("t2_busy1", bus.busy, 1);
        bus.req = '0;
        cycle();
        chk("t2_rvalid", bus.rvalid, 3'b010);
        chk("t2_rdata", bus.rdata, 13);
        chk("t2_busy2", bus.busy, 1);
        cycle();
        chk("t2_busy_off", bus.busy, 0);

        // Move the pointer back to 0 with a write r5 = 0x55 from requester 2.
        set_req(2, 1'b1, 5'd5, 8'h55);
        cycle();
        bus.req = '0;

        // All three requesting continuously: strict rotation.
        set_req(0, 1'b0, 5'd3, 8'd0);
        set_req(1, 1'b1, 5'd7, 8'h77);
        set_req(2, 1'b0, 5'd5, 8'd0);
        for (int t = 0; t < 6; t++) begin
            cycle();
            chk("t3_gnt", obs_gnt, seq[t]);
        end
        bus.req = '0;
        repeat (2) cycle();

        // Address 0: write forwarded, read returns zero.
        set_req(0, 1'b1, 5'd0, 8'h88);
        cycle();
        chk("t4_reg_w", bus.reg_w, 1);
        chk("t4_reg_addr", bus.reg_addr, 0);
        chk("t4_reg_wdata", bus.reg_wdata, 8'h88);
        bus.req = '0;
        set_req(1, 1'b0, 5'd0, 8'd0);
        cycle();
        bus.req = '0;
        cycle();
        chk("t4_rvalid", bus.rvalid, 3'b010);
        chk("t4_rdata", bus.rdata, 0);

        // Reset the cycle after a read grant: the read is dropped.
        set_req(2, 1'b0, 5'd3, 8'd0);
        cycle();
        bus.req = '0;
        nReset  = 1'b0;
        #1;
        chk("t5_reg_w", bus.reg_w, 0);
        chk("t5_reg_addr", bus.reg_addr, 0);
        chk("t5_reg_wdata", bus.reg_wdata, 0);
        chk("t5_rvalid", bus.rvalid, 0);
        chk("t5_busy", bus.busy, 0);
        set_req(0, 1'b1, 5'd1, 8'h11);
        set_req(1, 1'b1, 5'd2, 8'h22);
        set_req(2, 1'b1, 5'd4, 8'h44);
        #1;
        chk("t5_gnt", bus.gnt, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        nReset = 1'b1;
        chk("t5_no_w", bus.reg_w, 0);
        cycle();
        chk("t5_ptr0", obs_gnt, 3'b001);
        repeat (2) begin
            bus.req[last_w] = 1'b0;
            cycle();
        end
        bus.req = '0;
        repeat (3) cycle();

`ifdef REG_ARB_LOCK_EN
        // Locked requester 0 keeps priority until lock drops.
        set_req(0, 1'b1, 5'd9, 8'h01);
        set_req(1, 1'b1, 5'd10, 8'h02);
        bus.lock = 3'b001;
        repeat (3) begin
            cycle();
            chk("t6_lock_gnt", obs_gnt, 3'b001);
        end
        bus.lock = '0;
        cycle();
        chk("t6_last0", obs_gnt, 3'b001);
        cycle();
        chk("t6_then1", obs_gnt, 3'b010);
        bus.req = '0;
        cycle();
`endif

        // Randomized traffic honouring the hold-until-granted contract.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom));
`ifdef REG_ARB_LOCK_EN
            if ($urandom_range(0, 3) == 0) bus.lock = 3'($urandom_range(0, 7));
`endif
            cycle();
            if (last_w >= 0) bus.req[last_w] = 1'b0;
        end
        bus.req = '0;
`ifdef REG_ARB_LOCK_EN
        bus.lock = '0;
`endif
        repeat (3) cycle();
        chk("drain", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
